vchip8_key_poller: RTL
======================

# vchip8_key_poller

Avalon-MM initiator that periodically reads the 16-bit keypad input PIO (register word 0, read latency 1) and turns raw samples into debounced key state. It also produces a queue of key-press events for the CHIP-8 core, removing the need for the CPU to poll the PIO. It sits between the keypad PIO responder and the core's `FX0A`/`EX9E`/`EXA1` key logic.

## Interface
Parameters:
- `POLL_DIV`, 50000: clock cycles between poll requests; must be ≥ 4.
- `DEBOUNCE`, 4: number of consecutive identical samples required before the stable state changes; range 1–15.
- `PIO_ADDR`, 2'd0: word address of the PIO data register.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `avm_address`  out  2  constant `PIO_ADDR`.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  responder stall.
- `avm_readdata`  in  32  responder data; only bits [15:0] are used.
- `keys`  out  16  debounced key state; bit n = key n held.
- `any_key`  out  1  equals `|keys`.
- `press_valid`  out  1  at least one press event is pending.
- `press_idx`  out  4  lowest-numbered pending key.
- `press_ready`  in  1  consumer accepts the event.

## Operation
- Poll timer: free-running down-counter, reloads `POLL_DIV-1` on reaching 0.
  - Each expiry sets `poll_due`. Expiries merge while `poll_due` is already set.
- FSM states: IDLE, REQ, LAT, EVAL.
  - IDLE: when `poll_due` is set, clear it and go to REQ.
  - REQ: drive `avm_read`=1. Hold while `avm_waitrequest`=1. Go to LAT on the cycle where `avm_read && !avm_waitrequest`.
  - LAT: capture `avm_readdata[15:0]` into `sample`, then go to EVAL.
  - EVAL: run the debounce update, then go to IDLE.
- Debounce update (in EVAL):
  - If `sample == last`: `cnt` increments, saturating at `DEBOUNCE`.
  - Otherwise: `last <= sample`, `cnt <= 1`.
  - When the resulting `cnt == DEBOUNCE`: `keys <= last`.
- Press events:
  - `rise = new_keys & ~keys`.
  - `pending <= (pending & ~clr) | rise`, where `clr` is the one-hot of `press_idx` when `press_valid && press_ready`.
  - If the same bit is cleared and set in one cycle, set wins.
- Outputs:
  - `press_valid = |pending`.
  - `press_idx` = lowest set bit of `pending`, and 0 when `pending` is empty.
  - `press_idx` may change only after a handshake or a `pending` update.
- Key releases generate no event. A key that is pressed again while its event is still pending merges into the existing event.
- Bits [31:16] of `avm_readdata` are ignored.

## Timing
- Reset values:
  - Outputs `avm_read`=0, `keys`=0, `any_key`=0, `press_valid`=0, `press_idx`=0.
  - Internal state: `pending`=0, `sample`=0, `last`=0, `cnt`=0, `poll_due`=0, timer=`POLL_DIV-1`, FSM in IDLE.
- `avm_address` is constant `PIO_ADDR` at all times, including during reset.
- Reset asserted mid-transaction: `avm_read` is 0 in the cycle after the reset edge, and any late readdata is ignored.
- `avm_read` stays asserted until accepted and never drops while `avm_waitrequest`=1.
- With no wait states, a poll occupies IDLE→REQ→LAT→EVAL, i.e. 3 cycles from `avm_read` rising to the `keys`/`pending` update.
- `press_valid` rises 1 cycle after the EVAL edge that sets `pending`.
- Debounce latency: a press stable from poll k is reflected in `keys` after poll k+`DEBOUNCE`-1.
- The handshake clears the event on the same edge. The next pending index is presented the following cycle.

## Structure
- Shared package `vchip8_pkg` holds:
  - FSM state enum `kp_state_t`,
  - `KEY_W=16`,
  - `KEY_IDX_W=4`.
- Sub-module `vchip8_lowest_bit`: combinational 16→4 priority encoder with a `found` flag. Used for `press_idx`/`press_valid` and for the `clr` one-hot.
- Everything else stays in the top module.

## Test plan
Scenarios use `POLL_DIV`=8 and `DEBOUNCE`=3.
- Reset:
  - Assert `reset` for 2 cycles with a responder returning 16'hFFFF.
  - Require all outputs = 0 during reset.
  - Require the first `avm_read` 8 cycles after reset release.
- Wait states:
  - Responder holds `avm_waitrequest`=1 for 5 cycles.
  - Require `avm_read` held high throughout, exactly one accepted read, and `sample` captured from the cycle after acceptance.
- Debounce:
  - Responder returns 16'h0010 on polls 1–3.
  - Require `keys`=16'h0010 only after poll 3, then `press_valid`=1 and `press_idx`=4.
  - Pattern 0010, 0000, 0010 (bounce): require `keys` stays 0.
- Multiple presses:
  - Stable 16'h8201 with `press_ready`=0.
  - Require `press_idx`=0. Then pulse `press_ready` per event and require the sequence 0, 9, 15, then `press_valid`=0.
- Simultaneous clear and set:
  - Key 2 is accepted in the same cycle that EVAL produces a new rise on key 2.
  - Require `pending[2]` remains set.
- Reset mid-read:
  - Assert `reset` while in REQ with `avm_waitrequest`=1.
  - Require `avm_read`=0 next cycle and no spurious `keys` update.

Source files
------------

// File: rtl/vchip8_pkg.sv
// Shared types and widths for the CHIP-8 keypad poller blocks.
package vchip8_pkg;

    localparam int KEY_W     = 16;
    localparam int KEY_IDX_W = 4;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_REQ,
        KP_LAT,
        KP_EVAL
    } kp_state_t;

endpackage

// File: rtl/vchip8_lowest_bit.sv
// Combinational priority encoder: index of the lowest set bit, 0 when none.
module vchip8_lowest_bit
    import vchip8_pkg::*;
(
    input  logic [KEY_W-1:0]     vec,
    output logic [KEY_IDX_W-1:0] idx,
    output logic                 found
);

    // Scanning downward lets the lowest set bit overwrite higher ones.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = KEY_IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vchip8_key_poller.sv
// Polls the keypad PIO over Avalon-MM, debounces the raw samples and
// queues key-press events for the CHIP-8 core.
module vchip8_key_poller
    import vchip8_pkg::*;
#(
    parameter int         POLL_DIV = 50000,
    parameter int         DEBOUNCE = 4,
    parameter logic [1:0] PIO_ADDR = 2'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [1:0]           avm_address,
    output logic                 avm_read,
    input  logic                 avm_waitrequest,
    input  logic [31:0]          avm_readdata,
    output logic [KEY_W-1:0]     keys,
    output logic                 any_key,
    output logic                 press_valid,
    output logic [KEY_IDX_W-1:0] press_idx,
    input  logic                 press_ready
);

    localparam int                  TIMER_W      = $clog2(POLL_DIV);
    localparam logic [TIMER_W-1:0]  TIMER_RELOAD = TIMER_W'(POLL_DIV - 1);
    localparam logic [TIMER_W-1:0]  TIMER_ONE    = TIMER_W'(1);
    localparam logic [3:0]          DEB          = 4'(DEBOUNCE);

    kp_state_t          state;
    kp_state_t          state_next;
    logic [TIMER_W-1:0] timer;
    logic               poll_due;
    logic               poll_take;
    logic [KEY_W-1:0]   sample;
    logic [KEY_W-1:0]   last;
    logic [3:0]         cnt;
    logic [KEY_W-1:0]   pending;

    logic [KEY_W-1:0]   last_next;
    logic [3:0]         cnt_next;
    logic [KEY_W-1:0]   keys_next;
    logic [KEY_W-1:0]   rise;
    logic [KEY_W-1:0]   clr;
    logic               eval;
    logic               unused_hi;

    assign avm_address = PIO_ADDR;
    assign any_key     = |keys;
    assign unused_hi   = ^avm_readdata[31:16];
    assign poll_take   = (state == KP_IDLE) && poll_due;
    assign eval        = (state == KP_EVAL);

    // Expiry is flagged on the edge the counter reaches 0, so a new
    // expiry landing in the same cycle IDLE consumes poll_due is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer    <= TIMER_RELOAD;
            poll_due <= 1'b0;
        end else begin
            timer    <= (timer == '0) ? TIMER_RELOAD : timer - TIMER_ONE;
            poll_due <= (poll_due && !poll_take) || (timer == TIMER_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= KP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        avm_read   = 1'b0;
        case (state)
            KP_IDLE: begin
                if (poll_due) begin
                    state_next = KP_REQ;
                end
            end
            KP_REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    state_next = KP_LAT;
                end
            end
            KP_LAT:  state_next = KP_EVAL;
            KP_EVAL: state_next = KP_IDLE;
            default: state_next = KP_IDLE;
        endcase
    end

    // Debounce: keys follow last only once cnt has seen DEBOUNCE matches.
    always_comb begin
        last_next = last;
        cnt_next  = cnt;
        if (sample == last) begin
            if (cnt != DEB) begin
                cnt_next = cnt + 4'd1;
            end
        end else begin
            last_next = sample;
            cnt_next  = 4'd1;
        end
        keys_next = (cnt_next == DEB) ? last_next : keys;
    end

    assign rise = eval ? (keys_next & ~keys) : '0;
    assign clr  = (press_valid && press_ready) ? (KEY_W'(1) << press_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample  <= '0;
            last    <= '0;
            cnt     <= '0;
            keys    <= '0;
            pending <= '0;
        end else begin
            if (state == KP_LAT) begin
                sample <= avm_readdata[KEY_W-1:0];
            end
            if (eval) begin
                last <= last_next;
                cnt  <= cnt_next;
                keys <= keys_next;
            end
            // Set after clear: a fresh rise on the bit being accepted survives.
            pending <= (pending & ~clr) | rise;
        end
    end

    vchip8_lowest_bit u_lowest (
        .vec   (pending),
        .idx   (press_idx),
        .found (press_valid)
    );

endmodule
